// File: rtl/alu_pkg.sv
// Package for the multi-cycle ALU: opcode encodings and controller states.
// Shared by alu_mc (top) and its testbench.
package alu_pkg;

  localparam int unsigned OP_BITS = 4;

  // Opcodes 11-15 are unused and produce a result of 0.
  typedef enum logic [OP_BITS-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SRA  = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one partial-product step per cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands (a -> multiplicand, b -> multiplier), clear acc
//   run          perform one step this cycle
//   a, b         operands, sampled only on start
//   done         high during the final (WIDTH-th) step
//   product      accumulator value after this cycle's step (low WIDTH bits)
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    acc_next = acc;
    if (mplr[0]) acc_next = acc + mcand;
  end

  // The product is taken from acc_next so the result can be registered on
  // the same edge as the last step.
  assign product = acc_next;
  assign done    = run && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (start) begin
      mcand <= a;
      mplr  <= b;
      acc   <= '0;
      cnt   <= '0;
    end else if (run) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on input and output.
// Single-cycle ops register their result on the accept edge; mul runs the
// iterative multiplier for WIDTH cycles while busy is high.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     request handshake
//   a, b, alu_control       operands and opcode (b low SHAMT_W bits = shamt)
//   out_valid / out_ready   result handshake
//   result, zero            registered result and (result == 0)
//   busy                    multiply in progress
//   carry, ovf, neg         registered flags, present only when the
//                           ALU_FLAGS_EN macro is defined
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned OP_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry,
  output logic             ovf,
  output logic             neg
`endif
);

  state_e           state;
  state_e           state_next;
  logic [3:0]       op;
  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic             load;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] op_result;
  logic [WIDTH-1:0] load_value;
  logic [SHAMT_W-1:0] shamt;

  assign op        = alu_control[3:0];
  assign shamt     = b[SHAMT_W-1:0];
  assign busy      = (state == MUL);
  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL);
  assign mul_start = accept && is_mul;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .run     (busy),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    op_result = '0;
    case (op)
      OP_ADD:  op_result = a + b;
      OP_SUB:  op_result = a - b;
      OP_AND:  op_result = a & b;
      OP_OR:   op_result = a | b;
      OP_SLL:  op_result = a << shamt;
      OP_SRL:  op_result = a >> shamt;
      OP_SRA:  op_result = $signed(a) >>> shamt;
      OP_XOR:  op_result = a ^ b;
      OP_SLT:  op_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: op_result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: op_result = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = MUL;
      MUL:     if (mul_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A mul accept never loads; its result arrives via mul_done later.
  assign load       = (accept && !is_mul) || mul_done;
  assign load_value = mul_done ? mul_product : op_result;

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  logic           carry_next;
  logic           ovf_next;

  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};

  // sub carry is the inverse of the borrow (set when a >= b unsigned).
  always_comb begin
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    if (!mul_done) begin
      if (op == OP_ADD) begin
        carry_next = add_ext[WIDTH];
        ovf_next   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end else if (op == OP_SUB) begin
        carry_next = !sub_ext[WIDTH];
        ovf_next   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
      ovf   <= 1'b0;
      neg   <= 1'b0;
    end else if (load) begin
      carry <= carry_next;
      ovf   <= ovf_next;
      neg   <= load_value[WIDTH-1];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_value;
      zero      <= (load_value == '0);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
